// File: rtl/mem_pkg.sv
// Shared encodings and the queued-store record for the data-memory write path.
package mem_pkg;

   localparam int DEFAULT_DEPTH = 4;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   // One pending store, already in DM format (word address, lane data, byte enables).
   typedef struct packed {
      logic [29:0] addr;
      logic [31:0] data;
      logic [3:0]  be;
      logic [31:0] pc;
   } sb_entry_t;

endpackage

// File: rtl/store_buffer_align.sv
// Turns a raw MEM-stage store (size, low address bits, rt value) into byte enables and lane data.
module store_align
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  lowAddr,
   input  logic [31:0] data,
   output logic [3:0]  be,
   output logic [31:0] laneData,
   output logic        misalign
);

   always_comb begin
      be       = 4'b0000;
      laneData = data;
      misalign = 1'b0;
      case (size)
         SZ_WORD: begin
            be       = 4'b1111;
            misalign = (lowAddr != 2'b00);
         end
         SZ_HALF: begin
            be       = lowAddr[1] ? 4'b1100 : 4'b0011;
            laneData = {2{data[15:0]}};
            misalign = lowAddr[0];
         end
         SZ_BYTE: begin
            be       = 4'b0001 << lowAddr;
            laneData = {4{data[7:0]}};
         end
         default: misalign = 1'b1;
      endcase
   end

endmodule

// File: rtl/store_buffer.sv
// FIFO of formatted stores draining one per cycle into DM; loads hitting a pending word are stalled.
module store_buffer
   import mem_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int PTR_W = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             st_valid,
   input  logic [31:0]      st_addr,
   input  logic [31:0]      st_data,
   input  logic [1:0]       st_size,
   input  logic [31:0]      st_pc,
   output logic             st_ready,
   output logic             st_misalign,
   input  logic             ld_valid,
   input  logic [31:0]      ld_addr,
   output logic             ld_stall,
   output logic             dm_we,
   input  logic             dm_ready,
   output logic [31:0]      dm_addr,
   output logic [31:0]      dm_wdata,
   output logic [3:0]       dm_be,
   output logic [31:0]      dm_pc,
   output logic             empty,
   output logic [PTR_W:0]   count
);

   sb_entry_t        entries [DEPTH];
   sb_entry_t        headEntry;
   logic [PTR_W-1:0] wrPtr;
   logic [PTR_W-1:0] rdPtr;
   logic [3:0]       alignBe;
   logic [31:0]      alignData;
   logic             alignMis;
   logic             push;
   logic             pop;
   logic             hit;
   logic [1:0]       unusedLdLane;

   store_align u_align (
      .size     (st_size),
      .lowAddr  (st_addr[1:0]),
      .data     (st_data),
      .be       (alignBe),
      .laneData (alignData),
      .misalign (alignMis)
   );

   // Both sides use valid/ready: a transfer happens on a cycle where valid && ready at the rising edge.
   // Store side: ready depends only on occupancy (no same-cycle bypass of a popping slot).
   // DM side: dm_we is the valid, held with stable head fields until dm_ready completes it.
   assign st_misalign  = st_valid && alignMis;
   assign st_ready     = (count != (PTR_W+1)'(DEPTH));
   assign push         = st_valid && st_ready && !alignMis;
   assign empty        = (count == '0);
   assign dm_we        = !empty;
   assign pop          = dm_we && dm_ready;
   assign unusedLdLane = ld_addr[1:0];

   assign headEntry = entries[rdPtr];
   assign dm_addr   = {headEntry.addr, 2'b00};
   assign dm_wdata  = headEntry.data;
   assign dm_be     = headEntry.be;
   assign dm_pc     = headEntry.pc;

   // Slot i is live when its distance from the head is below the occupancy.
   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (({1'b0, PTR_W'(i) - rdPtr} < count) && (entries[i].addr == ld_addr[31:2]))
            hit = 1'b1;
      end
      ld_stall = ld_valid && hit;
   end

   always_ff @(posedge clk) begin
      if (push)
         entries[wrPtr] <= '{addr: st_addr[31:2], data: alignData, be: alignBe, pc: st_pc};
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push)
            wrPtr <= wrPtr + PTR_W'(1);
         if (pop)
            rdPtr <= rdPtr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
